// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the Sonata reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StWaitLock,
    StFilter,
    StRelease,
    StRun,
    StHold
  } rst_seq_state_e;

  localparam int unsigned LockLossCntW = 8;
  localparam int unsigned MaxDomains   = 16;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for bringing asynchronous levels into the clk_i domain.
module prim_flop_2sync #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rst_seq_sonata.sv
// Reset sequencer: qualifies PLL lock and releases per-domain resets in staggered order.
// Optional saturating lock-loss counter enabled by RST_SEQ_LOCK_LOSS_CNT_EN.
module rst_seq_sonata
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumDomains       = 4,
  parameter int unsigned LockFilterCycles = 1024,
  parameter int unsigned StageGapCycles   = 16,
  parameter int unsigned SwRstHoldCycles  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pll_locked_i,
  input  logic                    sw_rst_req_i,
  output logic [NumDomains-1:0]   rst_n_o,
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  output logic [LockLossCntW-1:0] lock_loss_cnt_o,
`endif
  output logic                    seq_done_o
);

  localparam int unsigned MaxCycles = max3(LockFilterCycles, StageGapCycles, SwRstHoldCycles);
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned IdxW      = (NumDomains > 1) ? $clog2(NumDomains) : 1;

  localparam logic [CntW-1:0] FilterLast = CntW'(LockFilterCycles - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(StageGapCycles - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(SwRstHoldCycles - 1);
  localparam logic [IdxW-1:0] IdxLast    = IdxW'(NumDomains - 1);

  if (NumDomains == 0 || NumDomains > MaxDomains) begin : gen_bad_num_domains
    $error("NumDomains must be in 1..%0d", MaxDomains);
  end
  if (LockFilterCycles == 0) begin : gen_bad_lock_filter
    $error("LockFilterCycles must be >= 1");
  end
  if (StageGapCycles == 0) begin : gen_bad_stage_gap
    $error("StageGapCycles must be >= 1");
  end
  if (SwRstHoldCycles == 0) begin : gen_bad_sw_hold
    $error("SwRstHoldCycles must be >= 1");
  end

  logic locked_q;

  prim_flop_2sync #(
    .Width      (1),
    .ResetValue (1'b0)
  ) u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_locked_i),
    .q_o    (locked_q)
  );

  rst_seq_state_e        state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       gap_q, gap_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic                  go_wait;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  logic [LockLossCntW-1:0] llc_q, llc_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    go_wait = 1'b0;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    llc_d   = llc_q;
`endif

    unique case (state_q)
      StWaitLock: begin
        rst_n_d = '0;
        cnt_d   = '0;
        if (locked_q) state_d = StFilter;
      end
      StFilter: begin
        if (!locked_q) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == FilterLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (!locked_q) begin
          go_wait = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = StHold;
          rst_n_d = '0;
          cnt_d   = '0;
        end else if (gap_q == GapLast) begin
          for (int unsigned i = 0; i < NumDomains; i++) begin
            if (idx_q == IdxW'(i)) rst_n_d[i] = 1'b1;
          end
          gap_d = '0;
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxLast) state_d = StRun;
        end else begin
          gap_d = gap_q + CntW'(1);
        end
      end
      StRun: begin
        if (!locked_q) begin
          go_wait = 1'b1;
        end else if (sw_rst_req_i) begin
          state_d = StHold;
          rst_n_d = '0;
          cnt_d   = '0;
        end
      end
      StHold: begin
        // sw_rst_req_i is deliberately not looked at here: a request mid-hold is dropped.
        if (!locked_q) begin
          go_wait = 1'b1;
        end else if (cnt_q == HoldLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StWaitLock;
        rst_n_d = '0;
      end
    endcase

    if (go_wait) begin
      state_d = StWaitLock;
      rst_n_d = '0;
      cnt_d   = '0;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
      if (llc_q != '1) llc_d = llc_q + LockLossCntW'(1);
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
      llc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
      llc_q   <= llc_d;
`endif
    end
  end

  assign rst_n_o    = rst_n_q;
  assign seq_done_o = (state_q == StRun);
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  assign lock_loss_cnt_o = llc_q;
`endif

endmodule

// File: tb/tb_rst_seq_sonata.sv
// Directed bench for rst_seq_sonata (NumDomains=3, LockFilterCycles=8, StageGapCycles=4,
// SwRstHoldCycles=5); lock-loss counter checks compile in with RST_SEQ_LOCK_LOSS_CNT_EN.
module tb_rst_seq_sonata;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       pll_locked_i;
  logic       sw_rst_req_i;
  logic [2:0] rst_n_o;
  logic       seq_done_o;
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt_o;
`endif

  rst_seq_sonata #(
    .NumDomains       (3),
    .LockFilterCycles (8),
    .StageGapCycles   (4),
    .SwRstHoldCycles  (5)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .pll_locked_i    (pll_locked_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .rst_n_o         (rst_n_o),
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    .lock_loss_cnt_o (lock_loss_cnt_o),
`endif
    .seq_done_o      (seq_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Each record: optionally restart from reset, advance to edge 'at', check, then drive inputs.
  typedef struct {
    bit         do_reset;
    int         at;
    logic       pll;
    logic       sw;
    logic [2:0] exp_rst;
    logic       exp_done;
    int         exp_llc;  // -1: not checked
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   e      = 0;

  function automatic vec_t mk(bit r, int at, logic pll, logic sw, logic [2:0] rs, logic dn,
                              int llc);
    vec_t v;
    v.do_reset = r;
    v.at       = at;
    v.pll      = pll;
    v.sw       = sw;
    v.exp_rst  = rs;
    v.exp_done = dn;
    v.exp_llc  = llc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic adv_to(input int target);
    while (e < target) begin
      tick();
      e++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, got, exp);
    end
  endtask

  // Leaves the DUT just after edge 0 with the synchroniser cleared.
  task automatic do_reset();
    rst_ni       = 1'b0;
    pll_locked_i = 1'b0;
    sw_rst_req_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    e = 0;
  endtask

  initial begin
    // Cold start, sw reset (with an ignored repeat request in HOLD), lock loss in RUN, re-lock.
    vecs.push_back(mk(1,  0, 1, 0, 3'b000, 0,  0));
    vecs.push_back(mk(0, 14, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 15, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 18, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 19, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 22, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 23, 1, 0, 3'b111, 1,  0));
    vecs.push_back(mk(0, 30, 1, 1, 3'b111, 1, -1));
    vecs.push_back(mk(0, 31, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 33, 1, 1, 3'b000, 0, -1));
    vecs.push_back(mk(0, 34, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 39, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 40, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 43, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 44, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 48, 1, 0, 3'b111, 1,  0));
    vecs.push_back(mk(0, 55, 0, 0, 3'b111, 1,  0));
    vecs.push_back(mk(0, 57, 0, 0, 3'b111, 1,  0));
    vecs.push_back(mk(0, 58, 0, 0, 3'b000, 0,  1));
    vecs.push_back(mk(0, 60, 1, 0, 3'b000, 0,  1));
    vecs.push_back(mk(0, 74, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 75, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 79, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 82, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 83, 1, 0, 3'b111, 1,  1));
    // Lock glitch during FILTER: release restarts, shifted by 9 edges.
    vecs.push_back(mk(1,  0, 1, 0, 3'b000, 0,  0));
    vecs.push_back(mk(0,  6, 0, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0,  9, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 15, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 23, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 24, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 27, 1, 0, 3'b001, 0, -1));
    vecs.push_back(mk(0, 28, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 31, 1, 0, 3'b011, 0, -1));
    vecs.push_back(mk(0, 32, 1, 0, 3'b111, 1,  0));
    // Lock drop and sw request land on the same edge (33): lock loss must win.
    vecs.push_back(mk(1,  0, 1, 0, 3'b000, 0,  0));
    vecs.push_back(mk(0, 23, 1, 0, 3'b111, 1, -1));
    vecs.push_back(mk(0, 30, 0, 0, 3'b111, 1, -1));
    vecs.push_back(mk(0, 31, 1, 0, 3'b111, 1, -1));
    vecs.push_back(mk(0, 32, 1, 1, 3'b111, 1, -1));
    vecs.push_back(mk(0, 33, 1, 0, 3'b000, 0,  1));
    vecs.push_back(mk(0, 42, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 45, 1, 0, 3'b000, 0, -1));
    vecs.push_back(mk(0, 46, 1, 0, 3'b001, 0,  1));

    // Reset values while rst_ni is held low.
    rst_ni       = 1'b0;
    pll_locked_i = 1'b1;
    sw_rst_req_i = 1'b0;
    #3;
    chk("reset rst_n_o", 32'(rst_n_o), 32'h0);
    chk("reset seq_done_o", 32'(seq_done_o), 32'h0);
    tick();
    chk("reset hold rst_n_o", 32'(rst_n_o), 32'h0);
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    chk("reset lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) do_reset();
      adv_to(vecs[i].at);
      chk($sformatf("vec%0d rst_n_o", i), 32'(rst_n_o), 32'(vecs[i].exp_rst));
      chk($sformatf("vec%0d seq_done_o", i), 32'(seq_done_o), 32'(vecs[i].exp_done));
`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
      if (vecs[i].exp_llc >= 0)
        chk($sformatf("vec%0d lock_loss_cnt_o", i), 32'(lock_loss_cnt_o),
            32'(vecs[i].exp_llc));
`endif
      pll_locked_i = vecs[i].pll;
      sw_rst_req_i = vecs[i].sw;
    end

    // Asynchronous reset in the middle of RELEASE clears outputs without a clock edge.
    do_reset();
    pll_locked_i = 1'b1;
    adv_to(16);
    chk("midrel rst_n_o before", 32'(rst_n_o), 32'h1);
    rst_ni = 1'b0;
    #2;
    chk("midrel rst_n_o async", 32'(rst_n_o), 32'h0);
    chk("midrel seq_done_o async", 32'(seq_done_o), 32'h0);
    adv_to(24);
    chk("midrel rst_n_o held", 32'(rst_n_o), 32'h0);

`ifdef RST_SEQ_LOCK_LOSS_CNT_EN
    // Saturation: reach RELEASE then drop lock, 300 times.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      pll_locked_i = 1'b1;
      repeat (12) tick();
      pll_locked_i = 1'b0;
      repeat (4) tick();
      if (n == 0) chk("sat first loss", 32'(lock_loss_cnt_o), 32'd1);
      if (n == 254) chk("sat at 255", 32'(lock_loss_cnt_o), 32'd255);
    end
    chk("sat after 300", 32'(lock_loss_cnt_o), 32'd255);
    // A glitch in FILTER is not a counted lock loss.
    pll_locked_i = 1'b1;
    repeat (6) tick();
    pll_locked_i = 1'b0;
    repeat (4) tick();
    chk("sat filter glitch", 32'(lock_loss_cnt_o), 32'd255);
    rst_ni = 1'b0;
    #2;
    chk("sat cleared by reset", 32'(lock_loss_cnt_o), 32'd0);
    rst_ni = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
